// File: rtl/multdiv_scheduler_pkg.sv
// Shared constants for the mult/div scheduler: aluop encodings, status register,
// exception codes and the controller state encoding.
package multdiv_scheduler_pkg;

  localparam logic [4:0] ALUOP_RTYPE = 5'b00000;
  localparam logic [4:0] ALUOP_MULT  = 5'b00110;
  localparam logic [4:0] ALUOP_DIV   = 5'b00111;

  localparam int unsigned DEF_RSTATUS_REG   = 30;
  localparam int unsigned DEF_MULT_EXC_CODE = 4;
  localparam int unsigned DEF_DIV_EXC_CODE  = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    RUN     = 2'd2,
    WAIT_WB = 2'd3
  } md_state_e;

endpackage

// File: rtl/multdiv_scheduler_wb_arbiter.sv
// Regfile write-port arbiter: the MW writeback always wins; the scheduler's
// pending result or exception code is granted only on a free cycle.
module multdiv_scheduler_wb_arbiter
  import multdiv_scheduler_pkg::*;
#(
  parameter int unsigned RSTATUS_REG   = DEF_RSTATUS_REG,
  parameter int unsigned MULT_EXC_CODE = DEF_MULT_EXC_CODE,
  parameter int unsigned DIV_EXC_CODE  = DEF_DIV_EXC_CODE
) (
  input  logic        req,
  input  logic        pipe_we,
  input  logic        exc,
  input  logic        op_div,
  input  logic        pending_valid,
  input  logic [4:0]  pending_rd,
  input  logic [31:0] result,
  output logic        pipe_hold,
  output logic        wb_sel,
  output logic        wb_we,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data
);

  always_comb begin
    wb_sel    = req && !pipe_we;
    pipe_hold = req && pipe_we;
    wb_we     = 1'b0;
    wb_reg    = '0;
    wb_data   = '0;
    if (wb_sel) begin
      // Exception writes bypass the WAW squash; normal results honour it.
      if (exc) begin
        wb_we   = 1'b1;
        wb_reg  = 5'(RSTATUS_REG);
        wb_data = op_div ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
      end else begin
        wb_we   = pending_valid;
        wb_reg  = pending_rd;
        wb_data = result;
      end
    end
  end

endmodule

// File: rtl/multdiv_scheduler.sv
// Sequences the shared multdiv unit beside the X stage: latches operands,
// pulses start, waits for the result (with timeout) and tracks the pending rd.
module multdiv_scheduler
  import multdiv_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT       = 40,
  parameter int unsigned RSTATUS_REG   = DEF_RSTATUS_REG,
  parameter int unsigned MULT_EXC_CODE = DEF_MULT_EXC_CODE,
  parameter int unsigned DIV_EXC_CODE  = DEF_DIV_EXC_CODE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  input  logic [4:0]  dec_rs,
  input  logic [4:0]  dec_rt,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  output logic        stall_issue,
  output logic        stall_hazard,
  output logic        pipe_hold,
  output logic        wb_sel,
  output logic        wb_we,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        busy
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  md_state_e   state, state_nxt;
  logic [CW-1:0] cnt;
  logic [4:0]  pending_rd;
  logic        pending_valid;
  logic        op_div;
  logic [31:0] result_q;
  logic        exc_q;
  logic        timeout_hit;

  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt    = state;
    busy         = (state != IDLE);
    md_ctrl_mult = (state == START) && !op_div;
    md_ctrl_div  = (state == START) && op_div;
    stall_issue  = issue_valid && (state != IDLE);
    stall_hazard = busy && pending_valid &&
                   ((dec_rs == pending_rd) || (dec_rt == pending_rd));
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (issue_valid) state_nxt = START;
        START:   state_nxt = RUN;
        RUN:     if (md_ready || timeout_hit) state_nxt = WAIT_WB;
        WAIT_WB: if (wb_sel) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      md_opA        <= '0;
      md_opB        <= '0;
      pending_rd    <= '0;
      pending_valid <= 1'b0;
      op_div        <= 1'b0;
      result_q      <= '0;
      exc_q         <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (issue_valid && !flush) begin
          md_opA        <= issue_a;
          md_opB        <= issue_b;
          pending_rd    <= issue_rd;
          pending_valid <= (issue_rd != '0);
          op_div        <= issue_is_div;
        end
        START: cnt <= '0;
        RUN: if (md_ready) begin
          result_q <= md_result;
          exc_q    <= md_exception;
        end else if (timeout_hit) begin
          exc_q <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        WAIT_WB: if (wb_sel) pending_valid <= 1'b0;
        default: ;
      endcase
      // A younger writer to the same rd or a flush retires the pending target.
      if ((busy && pipe_we && (pipe_rd == pending_rd)) || flush)
        pending_valid <= 1'b0;
    end
  end

  multdiv_scheduler_wb_arbiter #(
    .RSTATUS_REG   (RSTATUS_REG),
    .MULT_EXC_CODE (MULT_EXC_CODE),
    .DIV_EXC_CODE  (DIV_EXC_CODE)
  ) u_wb_arbiter (
    .req           ((state == WAIT_WB) && !flush),
    .pipe_we       (pipe_we),
    .exc           (exc_q),
    .op_div        (op_div),
    .pending_valid (pending_valid),
    .pending_rd    (pending_rd),
    .result        (result_q),
    .pipe_hold     (pipe_hold),
    .wb_sel        (wb_sel),
    .wb_we         (wb_we),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data)
  );

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Directed bench for multdiv_scheduler: mult/div flow, exceptions, hazards,
// write-port arbitration, flush, reset and timeout.
module tb_multdiv_scheduler;

  logic        clock, reset;
  logic        issue_valid, issue_is_div;
  logic [4:0]  issue_rd;
  logic [31:0] issue_a, issue_b;
  logic        flush;
  logic [31:0] md_result;
  logic        md_exception, md_ready;
  logic [31:0] md_opA, md_opB;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [4:0]  dec_rs, dec_rt;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic        stall_issue, stall_hazard, pipe_hold;
  logic        wb_sel, wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  multdiv_scheduler dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
    .issue_a(issue_a), .issue_b(issue_b), .flush(flush),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
    .md_opA(md_opA), .md_opB(md_opB), .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .pipe_we(pipe_we), .pipe_rd(pipe_rd),
    .stall_issue(stall_issue), .stall_hazard(stall_hazard), .pipe_hold(pipe_hold),
    .wb_sel(wb_sel), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic quiet();
    issue_valid = 0; issue_is_div = 0; issue_rd = 0; issue_a = 0; issue_b = 0;
    flush = 0; md_result = 0; md_exception = 0; md_ready = 0;
    dec_rs = 0; dec_rt = 0; pipe_we = 0; pipe_rd = 0;
  endtask

  task automatic present(input logic div, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b);
    issue_valid = 1; issue_is_div = div; issue_rd = rd; issue_a = a; issue_b = b;
  endtask

  task automatic test_reset();
    quiet();
    reset = 1;
    #12;
    total++;
    if ({busy, wb_sel, wb_we, md_ctrl_mult, md_ctrl_div, stall_issue, stall_hazard, pipe_hold} !== 8'h00) begin
      bad++; $display("FAIL reset_ctrl actual=%b required=00000000",
        {busy, wb_sel, wb_we, md_ctrl_mult, md_ctrl_div, stall_issue, stall_hazard, pipe_hold});
    end
    total++;
    if ({md_opA, md_opB} !== 64'h0) begin
      bad++; $display("FAIL reset_ops actual=%h_%h required=0", md_opA, md_opB);
    end
    reset = 0;
    tick();
  endtask

  task automatic test_mult();
    present(0, 5, 7, 6);
    #1;
    total++;
    if (stall_issue !== 1'b0) begin bad++; $display("FAIL mult_nostall actual=%b required=0", stall_issue); end
    tick(); quiet(); #1;
    total++;
    if ({md_ctrl_mult, md_ctrl_div, busy} !== 3'b101 || md_opA !== 32'd7 || md_opB !== 32'd6) begin
      bad++; $display("FAIL mult_start actual=%b%b%b a=%0d b=%0d required=101 a=7 b=6",
        md_ctrl_mult, md_ctrl_div, busy, md_opA, md_opB);
    end
    tick(); #1;
    total++;
    if (md_ctrl_mult !== 1'b0) begin bad++; $display("FAIL mult_pulse_width actual=%b required=0", md_ctrl_mult); end
    for (int i = 0; i < 32; i++) tick();
    md_ready = 1; md_result = 42;
    tick(); quiet(); md_result = 99; #1;
    total++;
    if ({wb_sel, wb_we} !== 2'b11 || wb_reg !== 5'd5 || wb_data !== 32'd42) begin
      bad++; $display("FAIL mult_wb actual=sel%b we%b r%0d d%0d required=sel1 we1 r5 d42",
        wb_sel, wb_we, wb_reg, wb_data);
    end
    tick(); #1;
    total++;
    if ({busy, wb_sel} !== 2'b00) begin bad++; $display("FAIL mult_done actual=%b%b required=00", busy, wb_sel); end
  endtask

  task automatic test_div_zero();
    present(1, 12, 10, 0);
    tick(); quiet(); #1;
    total++;
    if ({md_ctrl_div, md_ctrl_mult} !== 2'b10) begin
      bad++; $display("FAIL div_start actual=%b%b required=10", md_ctrl_div, md_ctrl_mult);
    end
    tick();
    md_ready = 1; md_exception = 1; md_result = 32'hdead;
    tick(); quiet(); #1;
    total++;
    if ({wb_sel, wb_we} !== 2'b11 || wb_reg !== 5'd30 || wb_data !== 32'd5) begin
      bad++; $display("FAIL div_exc_wb actual=sel%b we%b r%0d d%0d required=sel1 we1 r30 d5",
        wb_sel, wb_we, wb_reg, wb_data);
    end
    tick();
  endtask

  task automatic test_hazard();
    present(0, 8, 2, 2); dec_rs = 8; #1;
    total++;
    if (stall_hazard !== 1'b0) begin bad++; $display("FAIL hazard_idle actual=%b required=0", stall_hazard); end
    tick(); issue_valid = 0; #1;
    total++;
    if (stall_hazard !== 1'b1) begin bad++; $display("FAIL hazard_rs actual=%b required=1", stall_hazard); end
    dec_rs = 9; #1;
    total++;
    if (stall_hazard !== 1'b0) begin bad++; $display("FAIL hazard_other actual=%b required=0", stall_hazard); end
    dec_rt = 8; #1;
    total++;
    if (stall_hazard !== 1'b1) begin bad++; $display("FAIL hazard_rt actual=%b required=1", stall_hazard); end
    dec_rs = 8; dec_rt = 0;
    tick(); md_ready = 1; md_result = 4;
    tick(); md_ready = 0; #1;
    total++;
    if ({stall_hazard, wb_we} !== 2'b11 || wb_reg !== 5'd8) begin
      bad++; $display("FAIL hazard_wcycle actual=haz%b we%b r%0d required=haz1 we1 r8", stall_hazard, wb_we, wb_reg);
    end
    tick(); #1;
    total++;
    if (stall_hazard !== 1'b0) begin bad++; $display("FAIL hazard_drop actual=%b required=0", stall_hazard); end
    quiet();
  endtask

  task automatic test_arbitration();
    present(0, 4, 3, 5);
    tick(); quiet();
    tick(); md_ready = 1; md_result = 15;
    tick(); quiet(); pipe_we = 1; pipe_rd = 3; #1;
    total++;
    if ({wb_sel, wb_we, pipe_hold} !== 3'b001) begin
      bad++; $display("FAIL arb_conflict actual=sel%b we%b hold%b required=sel0 we0 hold1", wb_sel, wb_we, pipe_hold);
    end
    tick(); pipe_we = 0; #1;
    total++;
    if ({wb_sel, wb_we, pipe_hold} !== 3'b110 || wb_reg !== 5'd4 || wb_data !== 32'd15) begin
      bad++; $display("FAIL arb_grant actual=sel%b we%b hold%b r%0d d%0d required=sel1 we1 hold0 r4 d15",
        wb_sel, wb_we, pipe_hold, wb_reg, wb_data);
    end
    tick();
  endtask

  task automatic test_waw();
    present(0, 6, 1, 1);
    tick(); quiet();
    tick(); md_ready = 1; md_result = 11;
    tick(); quiet(); pipe_we = 1; pipe_rd = 6; #1;
    total++;
    if ({wb_sel, pipe_hold} !== 2'b01) begin
      bad++; $display("FAIL waw_conflict actual=sel%b hold%b required=sel0 hold1", wb_sel, pipe_hold);
    end
    tick(); pipe_we = 0; dec_rs = 6; #1;
    total++;
    if ({wb_sel, wb_we, stall_hazard} !== 3'b100) begin
      bad++; $display("FAIL waw_squash actual=sel%b we%b haz%b required=sel1 we0 haz0", wb_sel, wb_we, stall_hazard);
    end
    tick(); quiet();
  endtask

  task automatic test_back_to_back();
    present(0, 2, 1, 2);
    tick(); quiet();
    tick();
    present(1, 7, 9, 9); md_ready = 1; md_result = 2; #1;
    total++;
    if (stall_issue !== 1'b1) begin bad++; $display("FAIL b2b_stall_run actual=%b required=1", stall_issue); end
    tick(); md_ready = 0; #1;
    total++;
    if (stall_issue !== 1'b1 || wb_we !== 1'b1 || wb_reg !== 5'd2 || wb_data !== 32'd2) begin
      bad++; $display("FAIL b2b_first_wb actual=stall%b we%b r%0d d%0d required=stall1 we1 r2 d2",
        stall_issue, wb_we, wb_reg, wb_data);
    end
    tick(); #1;
    total++;
    if ({stall_issue, busy} !== 2'b00) begin bad++; $display("FAIL b2b_accept actual=%b%b required=00", stall_issue, busy); end
    tick(); issue_valid = 0; #1;
    total++;
    if (md_ctrl_div !== 1'b1 || md_opA !== 32'd9) begin
      bad++; $display("FAIL b2b_second_start actual=div%b a%0d required=div1 a9", md_ctrl_div, md_opA);
    end
    tick(); md_ready = 1; md_result = 1;
    tick(); quiet(); #1;
    total++;
    if (wb_we !== 1'b1 || wb_reg !== 5'd7 || wb_data !== 32'd1) begin
      bad++; $display("FAIL b2b_second_wb actual=we%b r%0d d%0d required=we1 r7 d1", wb_we, wb_reg, wb_data);
    end
    tick();
  endtask

  task automatic test_flush();
    present(0, 10, 21, 22);
    tick(); quiet(); flush = 1; #1;
    total++;
    if (md_ctrl_mult !== 1'b1) begin bad++; $display("FAIL flush_start_pulse actual=%b required=1", md_ctrl_mult); end
    tick(); flush = 0; #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle actual=%b required=0", busy); end
    present(0, 11, 55, 56); flush = 1;
    tick(); quiet(); md_ready = 1; md_result = 3; #1;
    total++;
    if (busy !== 1'b0 || md_opA !== 32'd21) begin
      bad++; $display("FAIL flush_wins actual=busy%b a%0d required=busy0 a21", busy, md_opA);
    end
    tick(); #1;
    total++;
    if ({busy, wb_sel} !== 2'b00) begin bad++; $display("FAIL ready_ignored actual=%b%b required=00", busy, wb_sel); end
    quiet();
  endtask

  task automatic test_rd_zero();
    present(0, 0, 5, 5);
    tick(); quiet();
    tick(); md_ready = 1; md_result = 77;
    tick(); quiet(); #1;
    total++;
    if ({wb_sel, wb_we} !== 2'b10) begin bad++; $display("FAIL rd0_nowrite actual=sel%b we%b required=sel1 we0", wb_sel, wb_we); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    present(0, 14, 123, 456); dec_rs = 14;
    tick(); issue_valid = 0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1; #1;
    total++;
    if ({busy, wb_sel, stall_hazard, md_ctrl_mult} !== 4'b0000 || md_opA !== 32'd0 || md_opB !== 32'd0) begin
      bad++; $display("FAIL reset_async actual=%b%b%b%b a%0d b%0d required=0000 a0 b0",
        busy, wb_sel, stall_hazard, md_ctrl_mult, md_opA, md_opB);
    end
    #1 reset = 0;
    md_ready = 1; md_result = 9;
    tick(); #1;
    total++;
    if ({busy, wb_sel, wb_we} !== 3'b000) begin bad++; $display("FAIL reset_nowrite actual=%b%b%b required=000", busy, wb_sel, wb_we); end
    quiet();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    present(0, 13, 1, 1);
    tick(); quiet();
    for (int i = 0; i < 40; i++) begin
      tick(); #1;
      if (wb_sel !== 1'b0 || busy !== 1'b1) early++;
    end
    total++;
    if (early != 0) begin bad++; $display("FAIL timeout_early actual=%0d required=0", early); end
    tick(); #1;
    total++;
    if ({wb_sel, wb_we} !== 2'b11 || wb_reg !== 5'd30 || wb_data !== 32'd4) begin
      bad++; $display("FAIL timeout_wb actual=sel%b we%b r%0d d%0d required=sel1 we1 r30 d4",
        wb_sel, wb_we, wb_reg, wb_data);
    end
    tick(); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle actual=%b required=0", busy); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_zero();
    test_hazard();
    test_arbitration();
    test_waw();
    test_back_to_back();
    test_flush();
    test_rd_zero();
    test_reset_mid_run();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
